// File: rtl/wght_fetch_pkg.sv
// Shared types for the weight-bank fetch arbiter: controller states and a
// saturating counter helper used by the optional performance counters.
package wght_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int PERF_W = 32;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/wght_fetch_arb_if.sv
// Loader, requester and response signals between the neuron cores/host loader
// (master) and the weight fetch arbiter (slave).
interface wght_fetch_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 14,
  parameter int DW      = 32,
  parameter int ID_W    = 2
) ();

  logic                          ld_valid;
  logic [AW-1:0]                 ld_addr;
  logic signed [DW-1:0]          ld_data;
  logic                          ld_ready;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][AW-1:0]    req_addr;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          rsp_valid;
  logic [ID_W-1:0]               rsp_id;
  logic signed [DW-1:0]          rsp_data;

  modport master (
    output ld_valid, ld_addr, ld_data, req_valid, req_addr,
    input  ld_ready, req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, req_valid, req_addr,
    output ld_ready, req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/wght_fetch_arb_rr_arbiter.sv
// Round-robin arbiter: scans req starting at the held pointer, issues at most
// one one-hot grant while advance is high, and moves the pointer past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr;
  logic            hit;
  int              idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hit    = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && advance && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

  // pointer only moves on an actual grant so idle cycles keep the priority order
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/wght_fetch_arb.sv
// Weight-bank fetch controller: LOAD phase fills the URAM from the host loader,
// RUN phase shares the read port round-robin. Optional counters: WGHT_FETCH_PERF_EN.
module wght_fetch_arb
  import wght_fetch_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int RAM_DEPTH      = 10485,
  parameter int BIT_WIDTH      = 31,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic [RAM_ADDR_WIDTH:0]   load_len,
  input  logic                      run_stop,
  output logic                      load_done,
  output logic                      busy,
  wght_fetch_arb_if.slave           bus,
  output logic                      ram_ren,
  output logic                      ram_wren,
  output logic [RAM_ADDR_WIDTH-1:0] ram_raddr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_wraddr,
  output logic [BIT_WIDTH:0]        ram_wrdat,
  input  logic [BIT_WIDTH:0]        ram_rdat
`ifdef WGHT_FETCH_PERF_EN
  ,
  output logic [31:0]               perf_grants,
  output logic [31:0]               perf_stalls
`endif
);

  localparam int AW = RAM_ADDR_WIDTH;

  state_t             state;
  logic [AW:0]        len;
  logic [AW:0]        cnt;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               arb_en;
  logic               ld_acc;
  logic               rsp_v;
  logic [ID_W-1:0]    rsp_id_q;

  // the run_stop cycle is dead for arbitration so DRAIN only has to cover one read
  assign arb_en = (state == S_RUN) && !run_stop;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (arb_en),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign bus.req_ready = gnt;
  assign bus.ld_ready  = (state == S_LOAD);
  assign ld_acc        = (state == S_LOAD) && bus.ld_valid;

  assign ram_wren   = ld_acc;
  assign ram_wraddr = ld_acc ? bus.ld_addr : '0;
  assign ram_wrdat  = ld_acc ? bus.ld_data : '0;

  assign ram_ren    = |gnt;
  assign ram_raddr  = ram_ren ? bus.req_addr[gnt_id] : '0;

  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = ram_rdat;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      cnt       <= '0;
      load_done <= 1'b0;
      rsp_v     <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      load_done <= 1'b0;
      // tag travels alongside the 1-cycle URAM read
      rsp_v     <= ram_ren;
      rsp_id_q  <= gnt_id;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            len <= load_len;
            cnt <= '0;
            if (load_len == '0) begin
              state     <= S_RUN;
              load_done <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (ld_acc) begin
            cnt <= cnt + 1'b1;
            if ((cnt + 1'b1) == len) begin
              load_done <= 1'b1;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (run_stop) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WGHT_FETCH_PERF_EN
  logic stall;

  assign stall = (state == S_RUN) && |(bus.req_valid & ~gnt);

  always_ff @(posedge clk) begin
    if (rst || ((state == S_IDLE) && load_start)) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      perf_grants <= sat_inc(perf_grants, ram_ren);
      perf_stalls <= sat_inc(perf_stalls, stall);
    end
  end
`endif

endmodule

// File: tb/tb_wght_fetch_arb.sv
// Directed bench for wght_fetch_arb: a phase/queue-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_wght_fetch_arb;

  localparam int N   = 4;
  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          run_stop;
  logic          load_done;
  logic          busy;
  logic          ram_ren;
  logic          ram_wren;
  logic [AW-1:0] ram_raddr;
  logic [AW-1:0] ram_wraddr;
  logic [DW-1:0] ram_wrdat;
  logic [DW-1:0] ram_rdat = '0;
`ifdef WGHT_FETCH_PERF_EN
  logic [31:0]   perf_grants;
  logic [31:0]   perf_stalls;
`endif

  wght_fetch_arb_if #(.NUM_REQ(N), .AW(AW), .DW(DW), .ID_W(IDW)) bus ();

  wght_fetch_arb #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .run_stop   (run_stop),
    .load_done  (load_done),
    .busy       (busy),
    .bus        (bus),
    .ram_ren    (ram_ren),
    .ram_wren   (ram_wren),
    .ram_raddr  (ram_raddr),
    .ram_wraddr (ram_wraddr),
    .ram_wrdat  (ram_wrdat),
    .ram_rdat   (ram_rdat)
`ifdef WGHT_FETCH_PERF_EN
    ,
    .perf_grants(perf_grants),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int wr_cnt = 0;

  // URAM behaviour: registered 1-cycle read
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_wraddr] <= ram_wrdat;
    if (ram_ren)  ram_rdat <= ram[ram_raddr];
    if (ram_wren) wr_cnt <= wr_cnt + 1;
  end

  // model state: phase 0 idle, 1 load, 2 run, 3 drain
  int            m_phase = 0;
  int            m_ptr   = 0;
  int            m_len   = 0;
  int            m_cnt   = 0;
  bit            m_pend  = 1'b0;
  int            m_rid   = 0;
  bit            m_done  = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
  end

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  int          cur_g;
  logic [N-1:0] exp_rdy;
  always_comb begin
    cur_g   = (m_phase == 2 && !run_stop) ? pick(bus.req_valid, m_ptr) : -1;
    exp_rdy = (cur_g >= 0) ? (N'(1) << cur_g) : '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_ptr <= 0; m_pend <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else begin
      m_pend <= (cur_g >= 0);
      m_done <= 1'b0;
      if (cur_g >= 0) begin
        m_rid   <= cur_g;
        m_rdata <= m_mem[bus.req_addr[cur_g]];
        m_ptr   <= (cur_g + 1) % N;
      end
      case (m_phase)
        0: if (load_start) begin
             m_len <= int'(load_len);
             m_cnt <= 0;
             if (load_len == 0) begin m_phase <= 2; m_done <= 1'b1; end
             else m_phase <= 1;
           end
        1: if (bus.ld_valid) begin
             m_mem[bus.ld_addr] <= $unsigned(bus.ld_data);
             m_cnt <= m_cnt + 1;
             if (m_cnt + 1 == m_len) begin m_done <= 1'b1; m_phase <= 2; end
           end
        2: if (run_stop) m_phase <= 3;
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("ram_ren", ram_ren, cur_g >= 0);
      if (cur_g >= 0) chk("ram_raddr", ram_raddr, bus.req_addr[cur_g]);
      chk("ld_ready", bus.ld_ready, m_phase == 1);
      chk("ram_wren", ram_wren, (m_phase == 1) && bus.ld_valid);
      if ((m_phase == 1) && bus.ld_valid) begin
        chk("ram_wraddr", ram_wraddr, bus.ld_addr);
        chk("ram_wrdat", ram_wrdat, $unsigned(bus.ld_data));
      end
      chk("rsp_valid", bus.rsp_valid, m_pend);
      if (m_pend) begin
        chk("rsp_id", bus.rsp_id, m_rid);
        chk("rsp_data", $unsigned(bus.rsp_data), m_rdata);
      end
      chk("load_done", load_done, m_done);
      chk("busy", busy, m_phase != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int            dvals [4] = '{-5, 7, 0, -1};
  logic [N-1:0]  gexp  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int            d4    [3] = '{11, -22, 33};

  initial begin
    rst = 1'b1; load_start = 1'b0; load_len = '0; run_stop = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.req_valid = '0; bus.req_addr = '0;
    step;
    chk_en = 1'b1;
    step;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_load_done", load_done, 0);
    rst = 1'b0;

    // 1: load 4 words back-to-back
    load_start = 1'b1; load_len = 15'd4; step; load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_addr = AW'(i); bus.ld_data = 32'(dvals[i]);
      step;
    end
    bus.ld_valid = 1'b0;
    chk("t1_load_done", load_done, 1);
    chk("t1_wr_cnt", 64'(wr_cnt), 4);
    chk("t1_ld_ready_off", bus.ld_ready, 0);
    step;
    chk("t1_done_pulse", load_done, 0);

    // 2: single read of addr 1
    bus.req_valid = 4'b0001; bus.req_addr[0] = 14'd1; #1;
    chk("t2_req_ready", bus.req_ready, 4'b0001);
    step; bus.req_valid = '0; #1;
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    chk("t2_rsp_id", bus.rsp_id, 0);
    chk("t2_rsp_data", $unsigned(bus.rsp_data), 32'h0000_0007);

    // 3: wrap pointer to 0 via req3, then all four held valid
    bus.req_valid = 4'b1000; bus.req_addr[3] = 14'd3; step;
    bus.req_addr[0] = 14'd0; bus.req_addr[1] = 14'd1; bus.req_addr[2] = 14'd2;
    bus.req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_grant", bus.req_ready, gexp[i]);
      chk("t3_rsp_id", bus.rsp_id, (i + 3) % 4);
      step;
    end
    bus.req_valid = '0;
    chk("t3_last_rsp", $unsigned(bus.rsp_data), 32'hFFFF_FFFF);
    step;

    // 5: stop with req1 waiting, drain, idle
    bus.req_valid = 4'b0010; step;
    run_stop = 1'b1; #1;
    chk("t5_no_grant", bus.req_ready, 0);
    chk("t5_prior_rsp", bus.rsp_valid, 1);
    step; run_stop = 1'b0; bus.req_valid = '0; #1;
    chk("t5_drain_busy", busy, 1);
    step;
    chk("t5_idle", busy, 0);

    // stray loader beat in IDLE is ignored
    bus.ld_valid = 1'b1; bus.ld_addr = 14'd9; bus.ld_data = 32'd99; step;
    bus.ld_valid = 1'b0;

    // 4: gapped load of 3 words with requests pending
    load_start = 1'b1; load_len = 15'd3; bus.req_valid = 4'hF; step; load_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.ld_valid = (c % 2 == 0);
      bus.ld_addr  = AW'(5 + c / 2);
      bus.ld_data  = 32'(d4[c / 2]);
      #1;
      chk("t4_ld_ready", bus.ld_ready, 1);
      chk("t4_no_grant", bus.req_ready, 0);
      step;
    end
    bus.ld_valid = 1'b0;
    bus.req_valid = 4'b0100; bus.req_addr[2] = 14'd6;
    chk("t4_wr_cnt", 64'(wr_cnt), 7);
    step; bus.req_valid = '0; #1;
    chk("t4_rsp_id", bus.rsp_id, 2);
    chk("t4_rsp_data", $unsigned(bus.rsp_data), 32'hFFFF_FFEA);

    // 6: reset with a grant outstanding, then zero-length load
    bus.req_valid = 4'b0001; bus.req_addr[0] = 14'd0; rst = 1'b1; #1;
    chk("t6_grant_in_rst", bus.req_ready, 4'b0001);
    step; rst = 1'b0; bus.req_valid = '0; #1;
    chk("t6_rsp_dropped", bus.rsp_valid, 0);
    chk("t6_busy", busy, 0);
    load_start = 1'b1; load_len = '0; step; load_start = 1'b0;
    chk("t6_load_done", load_done, 1);
    chk("t6_run", busy, 1);
    run_stop = 1'b1; step; run_stop = 1'b0;
    step; step;
    chk("t6_end_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
